// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between requesters.
// Multi-byte messages lock the transmitter; an idle timeout releases a stalled lock.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ID_W         = 1,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_we,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 locked
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [ID_W-1:0] RR_RST = ID_W'(NUM_REQ - 1);

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic            locked_q, locked_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [ID_W-1:0] win;
  logic            win_ok;
  logic [ID_W-1:0] scan_idx;
  logic            xfer;
  logic [7:0]      win_data;

  // While locked only the owner may win; otherwise scan from rr_q+1.
  always_comb begin
    win      = '0;
    win_ok   = 1'b0;
    scan_idx = '0;
    if (locked_q) begin
      win    = owner_q;
      win_ok = req_valid[owner_q];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        scan_idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
        if (!win_ok && req_valid[scan_idx]) begin
          win_ok = 1'b1;
          win    = scan_idx;
        end
      end
    end
  end

  assign xfer     = (state_q == IDLE) && !tx_busy && win_ok;
  assign win_data = req_data[int'(win)*8 +: 8];

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    gid_d    = gid_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          data_d  = win_data;
          gid_d   = win;
          rr_d    = win;
          cnt_d   = '0;
          state_d = ISSUE;
          if (req_last[win]) begin
            locked_d = 1'b0;
          end else begin
            locked_d = 1'b1;
            owner_d  = win;
          end
        end else if (locked_q && !req_valid[owner_q]
                     && LOCK_TIMEOUT != 0) begin
          if (cnt_q == TO_LAST) begin
            locked_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= 8'h00;
      gid_q    <= '0;
      owner_q  <= '0;
      rr_q     <= RR_RST;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_we    = (state_q == ISSUE);
  assign tx_data  = data_q;
  assign grant_id = gid_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model.
// Outputs are sampled 1ns after the falling edge; inputs change 1ns after rising.
module tb_uart_tx_arbiter;

  localparam int FRAME = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy;
  logic [0:0]  grant_id;
  logic        locked;

  logic        force_busy;
  int          frame_cnt;

  int checks;
  int failures;

  logic [1:0] s_ready;
  logic       s_we;
  logic [7:0] s_data;
  logic [0:0] s_gid;
  logic       s_locked;
  logic       s_busy;
  logic       acc_seen;
  logic [0:0] acc_id;
  logic [7:0] acc_data;

  uart_tx_arbiter #(
    .NUM_REQ(2),
    .ID_W(1),
    .LOCK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_we(tx_we),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter: busy rises the cycle after we and lasts FRAME cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 0;
    end else if (tx_we) begin
      frame_cnt <= FRAME;
    end else if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1;
    end
  end

  assign tx_busy = (frame_cnt != 0) || force_busy;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    s_ready  = req_ready;
    s_we     = tx_we;
    s_data   = tx_data;
    s_gid    = grant_id;
    s_locked = locked;
    s_busy   = tx_busy;
    acc_seen = |(req_valid & req_ready);
    acc_id   = req_ready[1] ? 1'b1 : 1'b0;
    acc_data = req_ready[1] ? req_data[15:8] : req_data[7:0];
    if (s_we) chk("we_while_busy", {31'd0, s_busy}, 32'd0);
    chk("ready_onehot", {31'd0, $onehot0(s_ready)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    acc_seen = 1'b0;
    while (!acc_seen && n < 40) begin
      tick();
      n++;
    end
    if (!acc_seen) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=none expected=accept", tag);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    s_busy = 1'b0;
    while (!s_busy && n < 40) begin
      tick();
      n++;
    end
    while (s_busy && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80 || s_busy) begin
      checks++;
      failures++;
      $error("FAIL wait_idle_timeout observed=%0d expected=<80", n);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    force_busy = 1'b0;
    req_valid  = 2'b00;
    req_data   = 16'h0000;
    req_last   = 2'b00;

    // Reset values
    tick();
    tick();
    chk("rst_we", {31'd0, s_we}, 32'd0);
    chk("rst_data", {24'd0, s_data}, 32'h00);
    chk("rst_ready", {30'd0, s_ready}, 32'd0);
    chk("rst_gid", {31'd0, s_gid}, 32'd0);
    chk("rst_locked", {31'd0, s_locked}, 32'd0);
    rst_n = 1'b1;

    // Single byte from requester 0
    req_valid = 2'b01;
    req_data  = 16'h0041;
    req_last  = 2'b01;
    tick();
    chk("t1_ready", {30'd0, s_ready}, 32'd1);
    req_valid = 2'b00;
    tick();
    chk("t1_we", {31'd0, s_we}, 32'd1);
    chk("t1_data", {24'd0, s_data}, 32'h41);
    chk("t1_gid", {31'd0, s_gid}, 32'd0);
    chk("t1_ready_off", {30'd0, s_ready}, 32'd0);
    tick();
    chk("t1_we_pulse", {31'd0, s_we}, 32'd0);
    wait_idle();
    chk("t1_locked", {31'd0, s_locked}, 32'd0);

    // Round-robin with both requesters valid
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 2'b11;
    req_last  = 2'b11;
    req_data  = 16'hB0A0;
    wait_accept("rr1");
    chk("rr1_id", {31'd0, acc_id}, 32'd0);
    chk("rr1_data", {24'd0, acc_data}, 32'hA0);
    req_data[7:0] = 8'hA1;
    wait_accept("rr2");
    chk("rr2_id", {31'd0, acc_id}, 32'd1);
    chk("rr2_data", {24'd0, acc_data}, 32'hB0);
    req_data[15:8] = 8'hB1;
    wait_accept("rr3");
    chk("rr3_id", {31'd0, acc_id}, 32'd0);
    chk("rr3_data", {24'd0, acc_data}, 32'hA1);
    wait_accept("rr4");
    chk("rr4_id", {31'd0, acc_id}, 32'd1);
    chk("rr4_data", {24'd0, acc_data}, 32'hB1);
    req_valid = 2'b00;
    wait_idle();

    // Lock: requester 1 sends three bytes while requester 0 waits
    req_valid = 2'b10;
    req_data  = 16'hC0D0;
    req_last  = 2'b01;
    wait_accept("lk1");
    chk("lk1_id", {31'd0, acc_id}, 32'd1);
    chk("lk1_data", {24'd0, acc_data}, 32'hC0);
    req_valid = 2'b11;
    req_data[15:8] = 8'hC1;
    wait_accept("lk2");
    chk("lk2_id", {31'd0, acc_id}, 32'd1);
    chk("lk2_data", {24'd0, acc_data}, 32'hC1);
    chk("lk2_locked", {31'd0, s_locked}, 32'd1);
    req_data[15:8] = 8'hC2;
    req_last = 2'b11;
    wait_accept("lk3");
    chk("lk3_id", {31'd0, acc_id}, 32'd1);
    chk("lk3_data", {24'd0, acc_data}, 32'hC2);
    chk("lk3_locked", {31'd0, s_locked}, 32'd1);
    req_valid = 2'b01;
    tick();
    chk("lk_release", {31'd0, s_locked}, 32'd0);
    wait_accept("lk4");
    chk("lk4_id", {31'd0, acc_id}, 32'd0);
    chk("lk4_data", {24'd0, acc_data}, 32'hD0);
    req_valid = 2'b00;
    wait_idle();

    // Lock timeout: owner 0 stalls after a non-last byte
    req_valid = 2'b01;
    req_data  = 16'h6655;
    req_last  = 2'b10;
    wait_accept("to0");
    chk("to0_id", {31'd0, acc_id}, 32'd0);
    req_valid = 2'b10;
    wait_idle();
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("to_held%0d", k), {31'd0, s_locked}, 32'd1);
      chk($sformatf("to_noready%0d", k), {30'd0, s_ready}, 32'd0);
    end
    tick();
    chk("to_cleared", {31'd0, s_locked}, 32'd0);
    chk("to_accept", {31'd0, acc_seen}, 32'd1);
    chk("to_accept_id", {31'd0, acc_id}, 32'd1);
    chk("to_accept_data", {24'd0, acc_data}, 32'h66);
    req_valid = 2'b00;
    wait_idle();

    // Busy guard in IDLE
    force_busy = 1'b1;
    req_valid  = 2'b01;
    req_data   = 16'h0077;
    req_last   = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bg_ready%0d", k), {30'd0, s_ready}, 32'd0);
      chk($sformatf("bg_we%0d", k), {31'd0, s_we}, 32'd0);
    end
    force_busy = 1'b0;
    tick();
    chk("bg_accept", {30'd0, s_ready}, 32'd1);
    chk("bg_data", {24'd0, acc_data}, 32'h77);
    req_valid = 2'b00;
    wait_idle();

    // Reset during WAIT_DONE with a lock held
    req_valid = 2'b10;
    req_data  = 16'h8800;
    req_last  = 2'b00;
    wait_accept("mr");
    chk("mr_id", {31'd0, acc_id}, 32'd1);
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    chk("mr_locked_pre", {31'd0, s_locked}, 32'd1);
    chk("mr_busy_pre", {31'd0, s_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_we", {31'd0, tx_we}, 32'd0);
    chk("mr_data", {24'd0, tx_data}, 32'h00);
    chk("mr_locked", {31'd0, locked}, 32'd0);
    chk("mr_gid", {31'd0, grant_id}, 32'd0);
    chk("mr_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b11;
    req_data  = 16'h9291;
    req_last  = 2'b11;
    rst_n     = 1'b1;
    tick();
    chk("mr_prio", {30'd0, s_ready}, 32'd1);
    chk("mr_prio_data", {24'd0, acc_data}, 32'h91);
    req_valid = 2'b00;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
